// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one EXE->MEM instruction, waits for its data_ok,
// aligns load data and hands the result to WB. Responses of flushed requests are dropped.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 197,
  parameter int MS_TO_WS_BUS_WD = 157
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       es_mem_req_pending,
  input  logic                       wb_flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic                       ms_to_ds_load_wait,
  output logic                       ms_to_ds_is_exc,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus
);

  logic                       ms_valid_reg, ms_valid_next;
  logic [ES_TO_MS_BUS_WD-1:0] bus_reg;
  logic                       data_have_reg, data_have_next;
  logic [31:0]                data_buf_reg, data_buf_next;
  logic [1:0]                 discard_cnt_reg, discard_cnt_next;
  logic [2:0]                 cnt_sum;

  // Field decode of the latched EXE->MEM bus
  logic        st_or_ld, res_from_mem, gr_we, res_from_csr, is_exc;
  logic [4:0]  load_op, dest;
  logic [31:0] alu_result, pc, csr_rdata;
  logic [5:0]  ecode;

  assign st_or_ld     = bus_reg[196];
  assign load_op      = bus_reg[195:191];
  assign res_from_mem = bus_reg[190];
  assign gr_we        = bus_reg[189];
  assign dest         = bus_reg[188:184];
  assign alu_result   = bus_reg[183:152];
  assign pc           = bus_reg[151:120];
  assign res_from_csr = bus_reg[119];
  assign csr_rdata    = bus_reg[118:87];
  assign is_exc       = bus_reg[86];
  assign ecode        = bus_reg[17:12];

  // An ALE exception means EXE never issued the request, so there is nothing to wait for.
  logic need_data, data_ok_acc, ms_ready_go, leaving;

  assign need_data   = ms_valid_reg & st_or_ld & ~(is_exc & (ecode == 6'h09));
  assign data_ok_acc = data_sram_data_ok & (discard_cnt_reg == 2'd0);
  assign ms_ready_go = ~need_data | data_have_reg | data_ok_acc;

  assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_reg & ms_ready_go & ~wb_flush;
  assign leaving        = ms_to_ws_valid & ws_allowin;

  // Load alignment: buffered data if we already have it, else the live response
  logic [31:0] load_src;
  logic [7:0]  src_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] aligned;
  logic [31:0] final_result;

  assign load_src = data_have_reg ? data_buf_reg : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign src_byte[gi] = load_src[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = src_byte[alu_result[1:0]];
  assign sel_half = alu_result[1] ? load_src[31:16] : load_src[15:0];

  always_comb begin
    aligned = load_src;
    if (load_op[0])      aligned = load_src;
    else if (load_op[1]) aligned = {{24{sel_byte[7]}}, sel_byte};
    else if (load_op[3]) aligned = {24'h0, sel_byte};
    else if (load_op[2]) aligned = {{16{sel_half[15]}}, sel_half};
    else if (load_op[4]) aligned = {16'h0, sel_half};
  end

  assign final_result = res_from_mem ? aligned :
                        res_from_csr ? csr_rdata : alu_result;

  assign ms_to_ws_bus = {gr_we & ~is_exc & ms_valid_reg, dest, final_result, pc, bus_reg[86:0]};

  assign ms_to_ds_dest      = (ms_valid_reg & gr_we) ? dest : 5'd0;
  assign ms_to_ds_result    = final_result;
  assign ms_to_ds_load_wait = ms_valid_reg & res_from_mem & ~data_have_reg;
  assign ms_to_ds_is_exc    = ms_valid_reg & is_exc;

  always_comb begin
    ms_valid_next = ms_valid_reg;
    if (wb_flush)        ms_valid_next = 1'b0;
    else if (ms_allowin) ms_valid_next = es_to_ms_valid;
  end

  always_comb begin
    data_have_next = data_have_reg;
    data_buf_next  = data_buf_reg;
    if (wb_flush | leaving) begin
      data_have_next = 1'b0;
    end else if (need_data & data_ok_acc & ~data_have_reg) begin
      data_have_next = 1'b1;
      data_buf_next  = data_sram_rdata;
    end
  end

  // Outstanding responses that belong to squashed requests; a flush may add
  // MEM's own unanswered request and EXE's already-accepted one.
  always_comb begin
    cnt_sum = {1'b0, discard_cnt_reg};
    if (data_sram_data_ok && discard_cnt_reg != 2'd0) cnt_sum = cnt_sum - 3'd1;
    if (wb_flush) begin
      cnt_sum = cnt_sum + {2'b0, need_data & ~data_have_reg & ~data_ok_acc}
                        + {2'b0, es_mem_req_pending};
    end
    discard_cnt_next = cnt_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_reg    <= 1'b0;
      bus_reg         <= '0;
      data_have_reg   <= 1'b0;
      data_buf_reg    <= 32'h0;
      discard_cnt_reg <= 2'd0;
    end else begin
      ms_valid_reg    <= ms_valid_next;
      data_have_reg   <= data_have_next;
      data_buf_reg    <= data_buf_next;
      discard_cnt_reg <= discard_cnt_next;
      if (es_to_ms_valid & ms_allowin) bus_reg <= es_to_ms_bus;
    end
  end

  discard_cnt_bound : assert property (@(posedge clk) disable iff (reset) cnt_sum <= 3'd2);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM->WB buses are queued at issue time and
// compared when the stage hands an instruction to WB.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [196:0] es_to_ms_bus;
  logic         es_mem_req_pending;
  logic         wb_flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [4:0]   ms_to_ds_dest;
  logic [31:0]  ms_to_ds_result;
  logic         ms_to_ds_load_wait;
  logic         ms_to_ds_is_exc;
  logic         ms_to_ws_valid;
  logic [156:0] ms_to_ws_bus;

  int n_vec  = 0;
  int n_miss = 0;
  logic [156:0] sb[$];

  mem_stage dut (
    .clk                (clk),
    .reset              (reset),
    .ws_allowin         (ws_allowin),
    .ms_allowin         (ms_allowin),
    .es_to_ms_valid     (es_to_ms_valid),
    .es_to_ms_bus       (es_to_ms_bus),
    .es_mem_req_pending (es_mem_req_pending),
    .wb_flush           (wb_flush),
    .data_sram_data_ok  (data_sram_data_ok),
    .data_sram_rdata    (data_sram_rdata),
    .ms_to_ds_dest      (ms_to_ds_dest),
    .ms_to_ds_result    (ms_to_ds_result),
    .ms_to_ds_load_wait (ms_to_ds_load_wait),
    .ms_to_ds_is_exc    (ms_to_ds_is_exc),
    .ms_to_ws_valid     (ms_to_ws_valid),
    .ms_to_ws_bus       (ms_to_ws_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [196:0] mk_es(input logic sl, input logic [4:0] lop, input logic rfm,
                                         input logic gw, input logic [4:0] dst, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic rfc, input logic [31:0] csr,
                                         input logic exc, input logic [5:0] ec);
    return {sl, lop, rfm, gw, dst, alu, pc, rfc, csr, exc, 3'b010, pc ^ 32'hA5A5_0000, alu,
            exc, ec, 9'h001, 3'b101};
  endfunction

  function automatic logic [156:0] exp_ms(input logic gw, input logic [4:0] dst, input logic [31:0] res,
                                          input logic [31:0] pc, input logic [31:0] alu,
                                          input logic exc, input logic [5:0] ec);
    return {gw, dst, res, pc, exc, 3'b010, pc ^ 32'hA5A5_0000, alu, exc, ec, 9'h001, 3'b101};
  endfunction

  // Drive phase is 1 time unit after the rising edge; checks happen 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handoff to WB must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL wb_unexpected: got bus %h, required no handoff", ms_to_ws_bus);
      end else begin
        logic [156:0] e;
        e = sb.pop_front();
        if (ms_to_ws_bus !== e) begin
          n_miss++;
          $display("FAIL wb_bus: got %h required %h", ms_to_ws_bus, e);
        end else begin
          $display("txn pc=%h result=%h gr_we=%0b dest=%0d ok", ms_to_ws_bus[118:87],
                   ms_to_ws_bus[150:119], ms_to_ws_bus[156], ms_to_ws_bus[155:151]);
        end
      end
    end
  end

  // Called at a drive phase; returns at the drive phase of the instruction's first MEM cycle.
  task automatic issue(input logic [196:0] b);
    int k;
    k = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    #3;
    while (!ms_allowin && k < 20) begin
      tick();
      #3;
      k++;
    end
    if (!ms_allowin) begin
      n_vec++;
      n_miss++;
      $display("FAIL issue_timeout: ms_allowin got %0b required 1", ms_allowin);
    end
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    #3;
    n_vec++;
    if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_hold: allowin/valid got %0b/%0b required 1/0", ms_allowin, ms_to_ws_valid);
    end
    tick();
    reset = 1'b0;
    #3;
    n_vec++;
    if (ms_to_ws_bus !== 157'd0 || ms_to_ds_dest !== 5'd0 || ms_to_ds_result !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_outputs: bus %h dest %0d result %h required all 0", ms_to_ws_bus,
               ms_to_ds_dest, ms_to_ds_result);
    end
    n_vec++;
    if (ms_to_ds_load_wait !== 1'b0 || ms_to_ds_is_exc !== 1'b0 || ms_allowin !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_flags: wait/exc/allowin got %0b/%0b/%0b required 0/0/1",
               ms_to_ds_load_wait, ms_to_ds_is_exc, ms_allowin);
    end
    tick();
  endtask

  task automatic test_alu_pass();
    sb.push_back(exp_ms(1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 32'h1234_5678, 1'b0, 6'h0));
    issue(mk_es(1'b0, 5'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 1'b0, 32'hCAFE_0000, 1'b0, 6'h0));
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_dest !== 5'd5 || ms_to_ds_result !== 32'h1234_5678) begin
      n_miss++;
      $display("FAIL alu_pass: valid %0b dest %0d result %h required 1 5 12345678",
               ms_to_ws_valid, ms_to_ds_dest, ms_to_ds_result);
    end
    tick();
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0 || ms_to_ds_dest !== 5'd0) begin
      n_miss++;
      $display("FAIL alu_drain: valid %0b dest %0d required 0 0", ms_to_ws_valid, ms_to_ds_dest);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [196:0] b [3];
    logic [31:0]  r [3];
    b[0] = mk_es(1'b0, 5'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0010, 32'h1C00_0100, 1'b1, 32'hC5C5_0001, 1'b0, 6'h0);
    r[0] = 32'hC5C5_0001;
    b[1] = mk_es(1'b0, 5'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0020, 32'h1C00_0104, 1'b0, 32'hC5C5_0002, 1'b0, 6'h0);
    r[1] = 32'h0000_0020;
    b[2] = mk_es(1'b0, 5'b0, 1'b0, 1'b0, 5'd3, 32'h0000_0030, 32'h1C00_0108, 1'b0, 32'h0, 1'b0, 6'h0);
    r[2] = 32'h0000_0030;
    sb.push_back(exp_ms(1'b1, 5'd1, r[0], 32'h1C00_0100, 32'h0000_0010, 1'b0, 6'h0));
    sb.push_back(exp_ms(1'b1, 5'd2, r[1], 32'h1C00_0104, 32'h0000_0020, 1'b0, 6'h0));
    sb.push_back(exp_ms(1'b0, 5'd3, r[2], 32'h1C00_0108, 32'h0000_0030, 1'b0, 6'h0));
    es_to_ms_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      es_to_ms_bus = b[i];
      if (i > 0) begin
        #3;
        n_vec++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ds_result !== r[i-1]) begin
          n_miss++;
          $display("FAIL b2b_%0d: valid %0b allowin %0b result %h required 1 1 %h", i - 1,
                   ms_to_ws_valid, ms_allowin, ms_to_ds_result, r[i-1]);
        end
      end
      tick();
    end
    es_to_ms_valid = 1'b0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== r[2] || ms_to_ds_dest !== 5'd0) begin
      n_miss++;
      $display("FAIL b2b_2: valid %0b result %h dest %0d required 1 %h 0", ms_to_ws_valid,
               ms_to_ds_result, ms_to_ds_dest, r[2]);
    end
    tick();
  endtask

  task automatic test_ld_b_wait();
    sb.push_back(exp_ms(1'b1, 5'd7, 32'hFFFF_FF80, 32'h1C00_0200, 32'h0000_1003, 1'b0, 6'h0));
    data_sram_data_ok = 1'b0;
    issue(mk_es(1'b1, 5'b00010, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'h1C00_0200, 1'b0, 32'h0, 1'b0, 6'h0));
    for (int c = 0; c < 2; c++) begin
      #3;
      n_vec++;
      if (ms_to_ds_load_wait !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin
        n_miss++;
        $display("FAIL ldb_wait_%0d: wait %0b valid %0b allowin %0b required 1 0 0", c,
                 ms_to_ds_load_wait, ms_to_ws_valid, ms_allowin);
      end
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8000_0000;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== 32'hFFFF_FF80) begin
      n_miss++;
      $display("FAIL ldb_result: valid %0b result %h required 1 ffffff80", ms_to_ws_valid, ms_to_ds_result);
    end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0 || ms_to_ds_load_wait !== 1'b0) begin
      n_miss++;
      $display("FAIL ldb_drain: valid %0b wait %0b required 0 0", ms_to_ws_valid, ms_to_ds_load_wait);
    end
    tick();
  endtask

  task automatic test_ld_hu_zero_bubble();
    sb.push_back(exp_ms(1'b1, 5'd8, 32'h0000_BEEF, 32'h1C00_0300, 32'h0000_2002, 1'b0, 6'h0));
    issue(mk_es(1'b1, 5'b10000, 1'b1, 1'b1, 5'd8, 32'h0000_2002, 32'h1C00_0300, 1'b0, 32'h0, 1'b0, 6'h0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== 32'h0000_BEEF) begin
      n_miss++;
      $display("FAIL ldhu_zero_bubble: valid %0b result %h required 1 0000beef", ms_to_ws_valid, ms_to_ds_result);
    end
    tick();
    data_sram_data_ok = 1'b0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL ldhu_drain: valid %0b required 0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    ws_allowin = 1'b0;
    sb.push_back(exp_ms(1'b1, 5'd11, 32'hFFFF_8001, 32'h1C00_0400, 32'h0000_3000, 1'b0, 6'h0));
    issue(mk_es(1'b1, 5'b00100, 1'b1, 1'b1, 5'd11, 32'h0000_3000, 32'h1C00_0400, 1'b0, 32'h0, 1'b0, 6'h0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_8001;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_ready: valid %0b allowin %0b required 1 0", ms_to_ws_valid, ms_allowin);
    end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_DEAD;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== 32'hFFFF_8001 || ms_to_ds_load_wait !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_buffered: valid %0b result %h wait %0b required 1 ffff8001 0",
               ms_to_ws_valid, ms_to_ds_result, ms_to_ds_load_wait);
    end
    tick();
    ws_allowin = 1'b1;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin
      n_miss++;
      $display("FAIL bp_release: valid %0b allowin %0b required 1 1", ms_to_ws_valid, ms_allowin);
    end
    tick();
    data_sram_rdata = 32'h0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_drain: valid %0b required 0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_flush_discard();
    issue(mk_es(1'b1, 5'b00001, 1'b1, 1'b1, 5'd9, 32'h0000_4000, 32'h1C00_0500, 1'b0, 32'h0, 1'b0, 6'h0));
    wb_flush           = 1'b1;
    es_mem_req_pending = 1'b1;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_valid: valid %0b required 0", ms_to_ws_valid);
    end
    tick();
    wb_flush           = 1'b0;
    es_mem_req_pending = 1'b0;
    #3;
    n_vec++;
    if (ms_to_ds_load_wait !== 1'b0 || ms_allowin !== 1'b1) begin
      n_miss++;
      $display("FAIL flush_empty: wait %0b allowin %0b required 0 1", ms_to_ds_load_wait, ms_allowin);
    end
    tick();
    sb.push_back(exp_ms(1'b1, 5'd10, 32'h3333_3333, 32'h1C00_0600, 32'h0000_5000, 1'b0, 6'h0));
    issue(mk_es(1'b1, 5'b00001, 1'b1, 1'b1, 5'd10, 32'h0000_5000, 32'h1C00_0600, 1'b0, 32'h0, 1'b0, 6'h0));
    for (int k = 0; k < 2; k++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
      #3;
      n_vec++;
      if (ms_to_ws_valid !== 1'b0 || ms_to_ds_load_wait !== 1'b1) begin
        n_miss++;
        $display("FAIL discard_%0d: valid %0b wait %0b required 0 1", k, ms_to_ws_valid, ms_to_ds_load_wait);
      end
      tick();
    end
    data_sram_rdata = 32'h3333_3333;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== 32'h3333_3333) begin
      n_miss++;
      $display("FAIL discard_consume: valid %0b result %h required 1 33333333", ms_to_ws_valid, ms_to_ds_result);
    end
    tick();
    data_sram_data_ok = 1'b0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL discard_drain: valid %0b required 0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_flush_with_data_ok();
    issue(mk_es(1'b1, 5'b00001, 1'b1, 1'b1, 5'd12, 32'h0000_5100, 32'h1C00_0700, 1'b0, 32'h0, 1'b0, 6'h0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h4444_4444;
    wb_flush          = 1'b1;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL flush_ok_valid: valid %0b required 0", ms_to_ws_valid);
    end
    tick();
    data_sram_data_ok = 1'b0;
    wb_flush          = 1'b0;
    tick();
    sb.push_back(exp_ms(1'b1, 5'd13, 32'h5555_5555, 32'h1C00_0800, 32'h0000_5200, 1'b0, 6'h0));
    issue(mk_es(1'b1, 5'b00001, 1'b1, 1'b1, 5'd13, 32'h0000_5200, 32'h1C00_0800, 1'b0, 32'h0, 1'b0, 6'h0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_result !== 32'h5555_5555) begin
      n_miss++;
      $display("FAIL flush_ok_next: valid %0b result %h required 1 55555555", ms_to_ws_valid, ms_to_ds_result);
    end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    tick();
  endtask

  task automatic test_store();
    sb.push_back(exp_ms(1'b0, 5'd0, 32'h0000_7000, 32'h1C00_0900, 32'h0000_7000, 1'b0, 6'h0));
    issue(mk_es(1'b1, 5'b00000, 1'b0, 1'b0, 5'd0, 32'h0000_7000, 32'h1C00_0900, 1'b0, 32'h0, 1'b0, 6'h0));
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin
      n_miss++;
      $display("FAIL store_wait: valid %0b allowin %0b required 0 0", ms_to_ws_valid, ms_allowin);
    end
    tick();
    data_sram_data_ok = 1'b1;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL store_done: valid %0b required 1", ms_to_ws_valid);
    end
    tick();
    data_sram_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_ale();
    data_sram_rdata = 32'h0BAD_F00D;
    sb.push_back(exp_ms(1'b0, 5'd3, 32'h0BAD_F00D, 32'h1C00_0A00, 32'h0000_6001, 1'b1, 6'h09));
    issue(mk_es(1'b1, 5'b00001, 1'b1, 1'b1, 5'd3, 32'h0000_6001, 32'h1C00_0A00, 1'b0, 32'h0, 1'b1, 6'h09));
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b1 || ms_to_ds_is_exc !== 1'b1 || ms_to_ws_bus[156] !== 1'b0) begin
      n_miss++;
      $display("FAIL ale: valid %0b is_exc %0b gr_we %0b required 1 1 0", ms_to_ws_valid,
               ms_to_ds_is_exc, ms_to_ws_bus[156]);
    end
    tick();
    data_sram_rdata = 32'h0;
    #3;
    n_vec++;
    if (ms_to_ws_valid !== 1'b0 || ms_to_ds_is_exc !== 1'b0) begin
      n_miss++;
      $display("FAIL ale_drain: valid %0b is_exc %0b required 0 0", ms_to_ws_valid, ms_to_ds_is_exc);
    end
    tick();
  endtask

  initial begin
    reset              = 1'b1;
    ws_allowin         = 1'b1;
    es_to_ms_valid     = 1'b0;
    es_to_ms_bus       = '0;
    es_mem_req_pending = 1'b0;
    wb_flush           = 1'b0;
    data_sram_data_ok  = 1'b0;
    data_sram_rdata    = 32'h0;
    #1;
    test_reset();
    test_alu_pass();
    test_back_to_back();
    test_ld_b_wait();
    test_ld_hu_zero_bubble();
    test_backpressure();
    test_flush_discard();
    test_flush_with_data_ok();
    test_store();
    test_ale();
    tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover: %0d entries still queued, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
